// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus between the MEM stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
    logic        dreq;
    logic        dwrite;
    logic [31:0] daddr;
    logic [1:0]  dsize;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        dready_n;
    logic        dbusy;
    logic        derr;

    modport master (
        output dreq, dwrite, daddr, dsize, wdata,
        input  rdata, dready_n, dbusy, derr
    );

    modport slave (
        input  dreq, dwrite, daddr, dsize, wdata,
        output rdata, dready_n, dbusy, derr
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory with byte/halfword/word access and one request in flight.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned accesses on derr instead of aligning them.
module dmem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    dmem_responder_if.slave io_bus
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_BYTE = 2'b10;
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_cnt_zero;
    logic            r_write;
    logic [1:0]      r_size;
    logic [1:0]      r_lane;
    logic            r_mis;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rdata;
    logic            r_dready_n;
    logic            r_dbusy;
    logic            r_derr;
    logic [31:0]     r_mem [DEPTH];

    logic [1:0]      w_lane;
    logic            w_mis;
    logic [31:0]     w_rd_word;
    logic [31:0]     w_rd_shift;
    logic [31:0]     w_rd_data;
    logic [3:0]      w_be;
    logic [31:0]     w_wr_data;
    logic            w_unused_addr;

    // Address bits above the storage window are ignored, so accesses wrap.
    assign w_unused_addr = ^io_bus.daddr[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        w_lane = io_bus.daddr[1:0];
        w_mis  = 1'b0;
        if (io_bus.dsize == SZ_HALF) begin
            w_mis = io_bus.daddr[0];
        end else if (io_bus.dsize != SZ_BYTE) begin
            w_mis = (io_bus.daddr[1:0] != 2'b00);
        end
    end
`else
    always_comb begin
        w_mis = 1'b0;
        case (io_bus.dsize)
            SZ_BYTE: w_lane = io_bus.daddr[1:0];
            SZ_HALF: w_lane = {io_bus.daddr[1], 1'b0};
            default: w_lane = 2'b00;
        endcase
    end
`endif

    always_comb begin
        w_rd_word  = r_mem[r_idx];
        w_rd_shift = w_rd_word >> {r_lane, 3'b000};
        case (r_size)
            SZ_BYTE: w_rd_data = {24'h000000, w_rd_shift[7:0]};
            SZ_HALF: w_rd_data = {16'h0000, w_rd_shift[15:0]};
            default: w_rd_data = w_rd_shift;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick the lane(s).
    always_comb begin
        case (r_size)
            SZ_BYTE: begin
                w_be      = 4'b0001 << r_lane;
                w_wr_data = {4{r_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be      = 4'b0011 << r_lane;
                w_wr_data = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be      = 4'b1111;
                w_wr_data = r_wdata;
            end
        endcase
    end

    // Storage is not reset; an aborted store never reaches RESP and so never writes.
    always_ff @(posedge clk) begin
        if (r_state == S_RESP && r_write && !r_mis) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cnt_zero <= 1'b0;
            r_write    <= 1'b0;
            r_size     <= '0;
            r_lane     <= '0;
            r_mis      <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_dready_n <= 1'b1;
            r_dbusy    <= 1'b0;
            r_derr     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.dreq) begin
                        r_state    <= S_WAIT;
                        r_cnt      <= LAT_M1;
                        r_cnt_zero <= 1'b0;
                        r_write    <= io_bus.dwrite;
                        r_size     <= io_bus.dsize;
                        r_lane     <= w_lane;
                        r_mis      <= w_mis;
                        r_idx      <= io_bus.daddr[AW+1:2];
                        r_wdata    <= io_bus.wdata;
                        r_dbusy    <= 1'b1;
                    end
                end
                // Counter reaching 0 is registered first, so RESP starts the
                // cycle after the counter reads 0 (LATENCY+1 edges after accept).
                S_WAIT: begin
                    if (r_cnt_zero) begin
                        r_state    <= S_RESP;
                        r_dready_n <= 1'b0;
                        r_derr     <= r_mis;
                        if (!r_write) begin
                            r_rdata <= r_mis ? '0 : w_rd_data;
                        end
                    end else if (r_cnt == '0) begin
                        r_cnt_zero <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    r_state    <= S_IDLE;
                    r_dready_n <= 1'b1;
                    r_derr     <= 1'b0;
                    r_dbusy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.rdata    = r_rdata;
    assign io_bus.dready_n = r_dready_n;
    assign io_bus.dbusy    = r_dbusy;
    assign io_bus.derr     = r_derr;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-addressed reference model with edge-count timing,
// per-cycle output comparison, directed literal cases and randomized traffic.
module tb_dmem_responder;
    localparam int DEPTH = 64;
    localparam int LAT   = 2;
    localparam int MB    = 4 * DEPTH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    dmem_responder_if bus();

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte memory plus the edge number at which a request was accepted.
    logic [7:0]  m_mem [MB];
    int          m_edge = 0;
    int          m_a    = 0;
    bit          m_act  = 1'b0;
    bit          m_wr   = 1'b0;
    bit          m_mis  = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_sz   = '0;

    function automatic void rules(input logic [31:0] a, input logic [1:0] sz,
                                  output int n, output int base, output bit mis);
        int lane;
        n    = (sz == 2'b10) ? 1 : (sz == 2'b01) ? 2 : 4;
        lane = int'(a[1:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
        mis  = (lane % n) != 0;
`else
        mis  = 1'b0;
        lane = lane - (lane % n);
`endif
        base = int'(a & 32'(MB - 1) & ~32'h3) + lane;
    endfunction

    always @(posedge clk or negedge rst) begin
        int n, b;
        bit mis;
        logic [31:0] v;
        if (!rst) begin
            m_act   = 1'b0;
            m_rdata = '0;
        end else begin
            m_edge++;
            if (m_act) begin
                rules(m_addr, m_sz, n, b, mis);
                if (m_edge == m_a + LAT + 1 && !m_wr) begin
                    v = '0;
                    if (!mis)
                        for (int i = 0; i < n; i++) v = v | (32'(m_mem[b+i]) << (8*i));
                    m_rdata = v;
                end
                if (m_edge == m_a + LAT + 2) begin
                    if (m_wr && !mis)
                        for (int i = 0; i < n; i++) m_mem[b+i] = m_data[8*i +: 8];
                    m_act = 1'b0;
                end
            end else if (bus.dreq) begin
                m_act  = 1'b1;
                m_a    = m_edge;
                m_wr   = bus.dwrite;
                m_addr = bus.daddr;
                m_sz   = bus.dsize;
                m_data = bus.wdata;
                rules(m_addr, m_sz, n, b, mis);
                m_mis  = mis;
            end
        end
    end

    always @(negedge clk) begin
        bit resp;
        if (chk_en) begin
            resp = m_act && (m_edge == m_a + LAT + 1);
            chk("dbusy",    32'(bus.dbusy),    32'(m_act));
            chk("dready_n", 32'(bus.dready_n), 32'(!resp));
            chk("derr",     32'(bus.derr),     32'(resp && m_mis));
            chk("rdata",    bus.rdata,         m_rdata);
        end
    end

    // One request from an idle DUT; lat = cycles from acceptance edge to dready_n low.
    task automatic xact(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] d, output int lat,
                        output logic [31:0] rd, output logic er);
        @(negedge clk);
        bus.dreq = 1'b1; bus.dwrite = wr; bus.daddr = a; bus.dsize = sz; bus.wdata = d;
        @(negedge clk);
        bus.dreq = 1'b0;
        lat = 0;
        while (bus.dready_n !== 1'b0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("xact completes", 32'(lat < 40), 32'd1);
        rd = bus.rdata;
        er = bus.derr;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          cnt;
        int          pos [3];
        logic [31:0] rd;
        logic        er;

        bus.dreq = 1'b0; bus.dwrite = 1'b0; bus.daddr = '0; bus.dsize = '0; bus.wdata = '0;
        pos = '{0, 0, 0};
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;

        repeat (5) begin
            @(negedge clk);
            chk("idle dbusy",    32'(bus.dbusy),    32'd0);
            chk("idle dready_n", 32'(bus.dready_n), 32'd1);
            chk("idle rdata",    bus.rdata,         32'd0);
        end

        for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(i*4), 2'b00, $urandom, lat, rd, er);

        xact(1'b1, 32'h10, 2'b00, 32'hDEADBEEF, lat, rd, er);
        chk("store latency", 32'(lat), 32'd3);
        xact(1'b0, 32'h10, 2'b00, 32'h0, lat, rd, er);
        chk("load latency", 32'(lat), 32'd3);
        chk("load word", rd, 32'hDEADBEEF);

        xact(1'b1, 32'h10, 2'b00, 32'h11223344, lat, rd, er);
        xact(1'b1, 32'h13, 2'b10, 32'hFFFFFFAA, lat, rd, er);
        xact(1'b0, 32'h12, 2'b01, 32'h0, lat, rd, er);
        chk("load half after byte store", rd, 32'h0000AA22);
        xact(1'b0, 32'h10, 2'b00, 32'h0, lat, rd, er);
        chk("load merged word", rd, 32'hAA223344);
        xact(1'b1, 32'h11, 2'b10, 32'h00000055, lat, rd, er);
        chk("store keeps rdata", rd, 32'hAA223344);
        xact(1'b0, 32'h11, 2'b10, 32'h0, lat, rd, er);
        chk("load byte", rd, 32'h00000055);

        xact(1'b1, 32'h10 + 32'(MB), 2'b00, 32'h0BADF00D, lat, rd, er);
        xact(1'b0, 32'hFFFF_FF10, 2'b00, 32'h0, lat, rd, er);
        chk("address wrap", rd, 32'h0BADF00D);

        @(negedge clk);
        bus.dreq = 1'b1; bus.dwrite = 1'b0; bus.daddr = 32'h10; bus.dsize = 2'b00;
        cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 11) bus.dreq = 1'b0;
            if (bus.dready_n === 1'b0) begin
                if (cnt < 3) pos[cnt] = k;
                cnt++;
            end
        end
        chk("held dreq pulses", 32'(cnt), 32'd3);
        chk("held pulse 1", 32'(pos[0]), 32'd4);
        chk("held pulse 2", 32'(pos[1]), 32'd9);
        chk("held pulse 3", 32'(pos[2]), 32'd14);

        xact(1'b1, 32'h20, 2'b00, 32'hCAFEF00D, lat, rd, er);
        @(negedge clk);
        bus.dreq = 1'b1; bus.dwrite = 1'b1; bus.daddr = 32'h20; bus.dsize = 2'b00;
        bus.wdata = 32'h12345678;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        bus.dreq = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.dready_n === 1'b0) cnt++;
        end
        chk("aborted store no dready_n", 32'(cnt), 32'd0);
        xact(1'b0, 32'h20, 2'b00, 32'h0, lat, rd, er);
        chk("aborted store kept word", rd, 32'hCAFEF00D);

        xact(1'b1, 32'h22, 2'b00, 32'h55667788, lat, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("misaligned store derr", 32'(er), 32'd1);
        xact(1'b0, 32'h20, 2'b00, 32'h0, lat, rd, er);
        chk("misaligned store no write", rd, 32'hCAFEF00D);
        xact(1'b0, 32'h21, 2'b01, 32'h0, lat, rd, er);
        chk("misaligned load rdata", rd, 32'h00000000);
        chk("misaligned load derr", 32'(er), 32'd1);
`else
        chk("unaligned store derr", 32'(er), 32'd0);
        xact(1'b0, 32'h20, 2'b00, 32'h0, lat, rd, er);
        chk("unaligned store writes word", rd, 32'h55667788);
        xact(1'b0, 32'h23, 2'b01, 32'h0, lat, rd, er);
        chk("unaligned half load", rd, 32'h00005566);
        chk("unaligned load derr", 32'(er), 32'd0);
`endif

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.dreq   = ($urandom_range(3) != 0);
            bus.dwrite = 1'($urandom_range(1));
            bus.daddr  = $urandom;
            bus.dsize  = 2'($urandom_range(3));
            bus.wdata  = $urandom;
            if ($urandom_range(249) == 0) begin
                @(posedge clk);
                #2 rst = 1'b0;
                @(posedge clk);
                #2 rst = 1'b1;
            end
        end
        @(negedge clk);
        bus.dreq = 1'b0;
        repeat (10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
